canvas_readback: RTL and testbench

//   Reads the 3-bit-per-pixel canvas RAM that the painting path fills, then streams the

---
 rtl/canvas_readback.sv | 139 +++++++++++++
 tb/tb_canvas_readback.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/canvas_readback.sv
// Streams one canvas frame out of the pixel RAM as packed two-pixel bytes over valid/ready.
// Each byte takes four cycles: two fetches, one latch and at least one send cycle.
module canvas_readback #(
   parameter int MAX_X      = 640,
   parameter int MAX_Y      = 480,
   parameter int ADDR_WIDTH = 19,
   parameter int DATA_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [7:0]            m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_WIDTH-1:0] NPIX = ADDR_WIDTH'(MAX_X * MAX_Y);

   typedef enum logic [2:0] {
      IDLE,
      FETCH_A,
      FETCH_B,
      LATCH,
      SEND,
      DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
   logic                    rd_en_q, rd_en_d;
   logic [DATA_WIDTH-1:0]   pixa_q, pixa_d;
   logic [7:0]              m_data_q, m_data_d;
   logic                    m_valid_q, m_valid_d;
   logic                    m_last_q, m_last_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         rd_addr_q <= '0;
         rd_en_q   <= 1'b0;
         pixa_q    <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         rd_addr_q <= rd_addr_d;
         rd_en_q   <= rd_en_d;
         pixa_q    <= pixa_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      rd_addr_d = rd_addr_q;
      rd_en_d   = rd_en_q;
      pixa_d    = pixa_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH_A;
               ptr_d   = '0;
               busy_d  = 1'b1;
            end
         end
         FETCH_A: begin
            rd_addr_d = ptr_q;
            rd_en_d   = 1'b1;
            ptr_d     = ptr_q + 1'b1;
            state_d   = FETCH_B;
         end
         FETCH_B: begin
            // rd_data here answers the even address issued in FETCH_A
            rd_addr_d = ptr_q;
            rd_en_d   = 1'b1;
            ptr_d     = ptr_q + 1'b1;
            pixa_d    = rd_data;
            state_d   = LATCH;
         end
         LATCH: begin
            rd_en_d   = 1'b0;
            m_data_d  = {1'b0, pixa_q[2:0], 1'b0, rd_data[2:0]};
            m_last_d  = (ptr_q == NPIX);
            m_valid_d = 1'b1;
            state_d   = SEND;
         end
         SEND: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               if (m_last_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = FETCH_A;
               end
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign rd_addr = rd_addr_q;
   assign rd_en   = rd_en_q;
   assign m_data  = m_data_q;
   assign m_valid = m_valid_q;
   assign m_last  = m_last_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_canvas_readback.sv
// Directed bench: a 4x2 canvas for sequencing/stall/reset cases and a 16x8 canvas
// for a full-frame boundary run.
module tb_canvas_readback;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // small instance: 4x2 canvas, pixel i holds i[2:0]
   logic       s_start = 1'b0, s_ready = 1'b1;
   logic [3:0] s_rd_addr;
   logic       s_rd_en, s_valid, s_last, s_busy, s_done;
   logic [2:0] s_rd_data;
   logic [7:0] s_data;
   assign s_rd_data = s_rd_addr[2:0];

   canvas_readback #(.MAX_X(4), .MAX_Y(2), .ADDR_WIDTH(4), .DATA_WIDTH(3)) u_small (
      .clk(clk), .reset(reset), .start(s_start), .rd_addr(s_rd_addr), .rd_en(s_rd_en),
      .rd_data(s_rd_data), .m_data(s_data), .m_valid(s_valid), .m_ready(s_ready),
      .m_last(s_last), .busy(s_busy), .done(s_done));

   // big instance: 16x8 canvas filled with 3'b101
   logic       b_start = 1'b0, b_ready = 1'b1;
   logic [7:0] b_rd_addr;
   logic       b_rd_en, b_valid, b_last, b_busy, b_done;
   logic [2:0] b_rd_data;
   logic [7:0] b_data;
   assign b_rd_data = 3'b101;

   canvas_readback #(.MAX_X(16), .MAX_Y(8), .ADDR_WIDTH(8), .DATA_WIDTH(3)) u_big (
      .clk(clk), .reset(reset), .start(b_start), .rd_addr(b_rd_addr), .rd_en(b_rd_en),
      .rd_data(b_rd_data), .m_data(b_data), .m_valid(b_valid), .m_ready(b_ready),
      .m_last(b_last), .busy(b_busy), .done(b_done));

   logic [7:0] q_data[$];
   logic       q_last[$];
   int         q_cyc[$];
   int         done_cnt = 0;

   always @(negedge clk) begin
      if (!reset && s_valid && s_ready) begin
         q_data.push_back(s_data);
         q_last.push_back(s_last);
         q_cyc.push_back(cyc);
      end
      if (s_done) done_cnt++;
   end

   int b_cnt = 0, b_bad = 0, b_lastcnt = 0, b_lastidx = 0, b_done_cnt = 0;
   int b_max_addr = 0;
   always @(negedge clk) begin
      if (b_rd_en && int'(b_rd_addr) > b_max_addr) b_max_addr = int'(b_rd_addr);
      if (b_valid && b_ready) begin
         b_cnt++;
         if (b_data != 8'h55) b_bad++;
         if (b_last) begin
            b_lastcnt++;
            b_lastidx = b_cnt;
         end
      end
      if (b_done) b_done_cnt++;
   end

   int s_cyc = 0;

   task automatic clear_log();
      q_data.delete();
      q_last.delete();
      q_cyc.delete();
      done_cnt = 0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 s_start = 1'b1;
      @(posedge clk); #1 s_cyc = cyc; s_start = 1'b0;
   endtask

   task automatic wait_done(input int target, input int limit);
      for (int i = 0; i < limit && done_cnt < target; i++) begin
         @(posedge clk); #1;
      end
      chk("done_wait", done_cnt, target);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic check_frame(input string tag);
      logic [7:0] exp_b [4];
      exp_b[0] = 8'h01; exp_b[1] = 8'h23; exp_b[2] = 8'h45; exp_b[3] = 8'h67;
      chk({tag, "_nbytes"}, q_data.size(), 4);
      if (q_data.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), q_data[i], exp_b[i]);
            chk($sformatf("%s_last%0d", tag, i), q_last[i], (i == 3) ? 1 : 0);
         end
      end
   endtask

   task automatic wait_bytes(input int n, input int limit);
      for (int i = 0; i < limit && q_data.size() < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_valid(input int limit);
      for (int i = 0; i < limit && !s_valid; i++) begin
         @(posedge clk); #1;
      end
      chk("valid_wait", s_valid, 1);
   endtask

   initial begin
      int stable;
      // 1: reset state and asynchronous reset during activity
      idle_cycles(3);
      chk("rst_outs", {s_rd_addr, s_rd_en, s_data, s_valid, s_last, s_busy, s_done}, 0);
      @(posedge clk); #1 reset = 1'b0;
      pulse_start();
      chk("busy_after_start", s_busy, 1);
      idle_cycles(5);
      #1 reset = 1'b1;
      #1 chk("async_rst_outs", {s_rd_addr, s_rd_en, s_data, s_valid, s_last, s_busy, s_done}, 0);
      @(posedge clk); #1 reset = 1'b0;
      idle_cycles(5);
      chk("post_rst_idle", {s_rd_addr, s_rd_en, s_data, s_valid, s_last, s_busy, s_done}, 0);

      // 2: basic frame, latency and throughput
      clear_log();
      pulse_start();
      wait_done(1, 100);
      check_frame("t2");
      if (q_cyc.size() == 4) begin
         chk("t2_latency", q_cyc[0] - s_cyc, 3);
         for (int i = 1; i < 4; i++) chk($sformatf("t2_rate%0d", i), q_cyc[i] - q_cyc[i-1], 4);
      end
      idle_cycles(2);
      chk("t2_done_once", done_cnt, 1);
      chk("t2_idle_busy", s_busy, 0);

      // 3: stall on byte 2
      clear_log();
      pulse_start();
      wait_bytes(1, 50);
      @(posedge clk); #1 s_ready = 1'b0;
      wait_valid(20);
      stable = 0;
      for (int i = 0; i < 5; i++) begin
         if (s_valid && s_data == 8'h23) stable++;
         @(posedge clk); #1;
      end
      chk("t3_stall_hold", stable, 5);
      chk("t3_stall_nbytes", q_data.size(), 1);
      s_ready = 1'b1;
      wait_done(1, 100);
      check_frame("t3");

      // 4: start while busy and on DONE is ignored
      clear_log();
      pulse_start();
      idle_cycles(3);
      pulse_start();
      for (int i = 0; i < 100 && !s_done; i++) begin
         @(posedge clk); #1;
      end
      chk("t4_saw_done", s_done, 1);
      s_start = 1'b1;
      @(posedge clk); #1 s_start = 1'b0;
      idle_cycles(10);
      check_frame("t4");
      chk("t4_done_once", done_cnt, 1);
      chk("t4_idle", s_busy, 0);
      clear_log();
      pulse_start();
      wait_done(1, 100);
      check_frame("t4_replay");

      // 5: reset during SEND of byte 2
      clear_log();
      pulse_start();
      wait_bytes(1, 50);
      @(posedge clk); #1 s_ready = 1'b0;
      wait_valid(20);
      #2 reset = 1'b1;
      #1 chk("t5_rst_valid", {s_valid, s_busy, s_data}, 0);
      @(posedge clk); #1 reset = 1'b0;
      s_ready = 1'b1;
      idle_cycles(10);
      chk("t5_no_done", done_cnt, 0);
      clear_log();
      pulse_start();
      idle_cycles(1);
      chk("t5_first_addr", s_rd_addr, 0);
      wait_done(1, 100);
      check_frame("t5");

      // 6: full frame on the 16x8 canvas
      @(posedge clk); #1 b_start = 1'b1;
      @(posedge clk); #1 b_start = 1'b0;
      for (int i = 0; i < 1000 && b_done_cnt == 0; i++) begin
         @(posedge clk); #1;
      end
      idle_cycles(3);
      chk("t6_bytes", b_cnt, 64);
      chk("t6_bad", b_bad, 0);
      chk("t6_lastcnt", b_lastcnt, 1);
      chk("t6_lastidx", b_lastidx, 64);
      chk("t6_max_addr", b_max_addr, 127);
      chk("t6_done", b_done_cnt, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
